// File: rtl/reg_access_master.sv
// Register-bus initiator: one read/write command in, reg_num load / legality check / strobe / readback, one response out.
// Latency accept->rsp_valid: write miss 4, read miss 4+RD_WAIT, write hit 2, read hit 2+RD_WAIT, illegal 3.
// Backpressure: cmd_ready only in IDLE; the response is held stable until rsp_valid & rsp_ready.
module reg_access_master #(
    parameter int unsigned RD_WAIT    = 1,
    parameter bit          ADDR_CACHE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_reg_num,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic        rsp_illegal,
    output logic [31:0] rsp_rdata,
    input  logic        cache_inval,
    output logic [31:0] bus_data_out,
    output logic        bus_reg_num_le,
    output logic        bus_wr_en,
    output logic        bus_rd_en,
    input  logic [31:0] bus_data_in,
    input  logic        bus_illegal_reg_num
);

    localparam logic [3:0] RD_WAIT_C = 4'(RD_WAIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CHECK,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;

    // latched command
    logic        wr_q;
    logic [31:0] reg_num_q;
    logic [31:0] wdata_q;

    // read wait counter and reg-number cache
    logic [3:0]  cnt_q;
    logic        cache_valid_q;
    logic [31:0] cached_num_q;

    // registered outputs and their next values
    logic        cmd_ready_q, rsp_valid_q, rsp_write_q, rsp_illegal_q;
    logic [31:0] rsp_rdata_q, bus_data_q;
    logic        le_q, wr_en_q, rd_en_q;
    logic        cmd_ready_d, rsp_valid_d, le_d, wr_en_d, rd_en_d;
    logic [31:0] bus_data_d;

    logic        accept;
    logic        cache_hit;
    logic        last_wait;
    logic        cur_wr;
    logic [31:0] cur_reg, cur_wdata;

    assign accept    = cmd_valid & cmd_ready_q;
    assign cache_hit = ADDR_CACHE && cache_valid_q && (cmd_reg_num == cached_num_q);
    assign last_wait = (state_q == S_WAIT) && (cnt_q <= 4'd1);

    // Outputs are registered from the next state, so the command fields come
    // straight from the ports in the accept cycle and from the latches after.
    assign cur_wr    = (state_q == S_IDLE) ? cmd_write   : wr_q;
    assign cur_reg   = (state_q == S_IDLE) ? cmd_reg_num : reg_num_q;
    assign cur_wdata = (state_q == S_IDLE) ? cmd_wdata   : wdata_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: the phase sequence for one command
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = cache_hit ? S_ACCESS : S_ADDR;
            S_ADDR:   state_d = S_CHECK;
            S_CHECK:  state_d = bus_illegal_reg_num ? S_RESP : S_ACCESS;
            S_ACCESS: state_d = wr_q ? S_RESP : S_WAIT;
            S_WAIT:   if (last_wait) state_d = S_RESP;
            S_RESP:   if (rsp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state; only one strobe can be active and data is zero otherwise
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        le_d        = (state_d == S_ADDR);
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        bus_data_d  = '0;
        if (state_d == S_ADDR) begin
            bus_data_d = cur_reg;
        end
        if (state_d == S_ACCESS) begin
            if (cur_wr) begin
                wr_en_d    = 1'b1;
                bus_data_d = cur_wdata;
            end else begin
                rd_en_d    = 1'b1;
            end
        end
    end

    // Output registers; reset drops every strobe on the next edge
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            le_q        <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            bus_data_q  <= '0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            le_q        <= le_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            bus_data_q  <= bus_data_d;
        end
    end

    // Command latch, wait counter and response fields
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q          <= 1'b0;
            reg_num_q     <= '0;
            wdata_q       <= '0;
            cnt_q         <= '0;
            rsp_write_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            if (accept) begin
                wr_q          <= cmd_write;
                reg_num_q     <= cmd_reg_num;
                wdata_q       <= cmd_wdata;
                rsp_write_q   <= cmd_write;
                rsp_illegal_q <= 1'b0;
                rsp_rdata_q   <= '0;
            end
            if (state_q == S_CHECK && bus_illegal_reg_num) begin
                rsp_illegal_q <= 1'b1;
            end
            if (state_q == S_ACCESS) begin
                cnt_q <= RD_WAIT_C;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (last_wait) begin
                rsp_rdata_q <= bus_data_in;
            end
        end
    end

    // Reg-number cache: filled by a legal CHECK, cleared by an illegal one or by invalidation
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_valid_q <= 1'b0;
            cached_num_q  <= '0;
        end else begin
            if (state_q == S_CHECK) begin
                if (bus_illegal_reg_num) begin
                    cache_valid_q <= 1'b0;
                end else begin
                    cache_valid_q <= 1'b1;
                    cached_num_q  <= reg_num_q;
                end
            end
            // invalidation wins over a same-cycle fill
            if (cache_inval) begin
                cache_valid_q <= 1'b0;
            end
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_write      = rsp_write_q;
    assign rsp_illegal    = rsp_illegal_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign bus_data_out   = bus_data_q;
    assign bus_reg_num_le = le_q;
    assign bus_wr_en      = wr_en_q;
    assign bus_rd_en      = rd_en_q;

endmodule

// File: tb/tb_reg_access_master.sv
// Bench for reg_access_master with a behavioural receiver and a transaction-level reference model.
// Latency: checked per command against the accept-relative cycle table.
// Backpressure: rsp_ready is withheld for random or fixed windows while stability is checked.
module tb_reg_access_master;

    localparam int RD_WAIT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_reg_num, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_illegal;
    logic [31:0] rsp_rdata;
    logic        cache_inval;
    logic [31:0] bus_data_out, bus_data_in;
    logic        bus_reg_num_le, bus_wr_en, bus_rd_en, bus_illegal_reg_num;

    int total = 0;
    int bad   = 0;

    always #4 clk = ~clk;

    reg_access_master #(.RD_WAIT(RD_WAIT), .ADDR_CACHE(1'b1)) dut (
        .clk                 (clk),
        .reset               (reset),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_write           (cmd_write),
        .cmd_reg_num         (cmd_reg_num),
        .cmd_wdata           (cmd_wdata),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_write           (rsp_write),
        .rsp_illegal         (rsp_illegal),
        .rsp_rdata           (rsp_rdata),
        .cache_inval         (cache_inval),
        .bus_data_out        (bus_data_out),
        .bus_reg_num_le      (bus_reg_num_le),
        .bus_wr_en           (bus_wr_en),
        .bus_rd_en           (bus_rd_en),
        .bus_data_in         (bus_data_in),
        .bus_illegal_reg_num (bus_illegal_reg_num)
    );

    // Receiver: 32 registers, numbers >= 32 are illegal, registered readback
    logic [31:0] rx_reg, rx_tx;
    logic        rx_ill;
    logic [31:0] rx_mem [32];

    always @(posedge clk) begin
        if (reset) begin
            rx_ill <= 1'b0;
            rx_tx  <= '0;
            rx_reg <= '0;
        end else begin
            if (bus_reg_num_le) begin
                rx_reg <= bus_data_out;
                rx_ill <= (bus_data_out >= 32);
            end
            if (bus_wr_en && rx_reg < 32) rx_mem[rx_reg[4:0]] <= bus_data_out;
            if (bus_rd_en) rx_tx <= (rx_reg < 32) ? rx_mem[rx_reg[4:0]] : 32'd0;
        end
    end
    assign bus_data_in         = rx_tx;
    assign bus_illegal_reg_num = rx_ill;

    // Reference model state
    bit          m_cv;
    logic [31:0] m_cn;
    logic [31:0] m_mem [32];

    typedef struct {
        int          le_cyc, wr_cyc, rd_cyc, rsp_cyc, n_le, n_wr, n_rd, proto_err, unstable;
        logic [31:0] le_dat, wr_dat, rsp_rd;
        logic        rsp_w, rsp_ill, rdy_after, vld_after;
        bit          timeout;
    } obs_t;

    typedef struct {
        bit          hit, ill;
        int          n_le, n_wr, n_rd, acc, rsp;
        logic [31:0] rdata;
    } exp_t;

    // Transaction-level prediction; also advances the model's cache and memory
    task automatic model_step(input logic w, input logic [31:0] rn, input logic [31:0] wd,
                              input int hold, input int inval_cyc, output exp_t e);
        bit inv;
        e.hit  = m_cv && (rn == m_cn);
        e.ill  = !e.hit && (rn >= 32);
        e.n_le = e.hit ? 0 : 1;
        e.acc  = e.hit ? 1 : 3;
        e.n_wr = 0;
        e.n_rd = 0;
        e.rdata = '0;
        if (e.ill) begin
            e.rsp = 3;
        end else if (w) begin
            e.rsp  = e.acc + 1;
            e.n_wr = 1;
            m_mem[rn[4:0]] = wd;
        end else begin
            e.rsp   = e.acc + 1 + RD_WAIT;
            e.n_rd  = 1;
            e.rdata = m_mem[rn[4:0]];
        end
        inv = (inval_cyc >= 1) && (inval_cyc <= e.rsp + hold);
        if (e.ill) m_cv = 0;
        else if (!e.hit) begin
            m_cv = !(inv && inval_cyc >= 2);
            m_cn = rn;
        end else if (inv) m_cv = 0;
    endtask

    // Drives one command, observes the bus cycle by cycle, withholds rsp_ready for 'hold' cycles
    task automatic run_cmd(input logic w, input logic [31:0] rn, input logic [31:0] wd,
                           input int hold, input int inval_cyc, output obs_t o);
        int cyc, held, st, wc;
        bit got, done;
        o.le_cyc = -1; o.wr_cyc = -1; o.rd_cyc = -1; o.rsp_cyc = -1;
        o.n_le = 0; o.n_wr = 0; o.n_rd = 0; o.proto_err = 0; o.unstable = 0;
        o.le_dat = '0; o.wr_dat = '0; o.rsp_rd = '0; o.rsp_w = 0; o.rsp_ill = 0;
        o.rdy_after = 0; o.vld_after = 1; o.timeout = 0;
        @(negedge clk);
        wc = 0;
        while (!cmd_ready && wc < 50) begin
            @(negedge clk);
            wc++;
        end
        if (!cmd_ready) begin
            o.timeout = 1;
            return;
        end
        cmd_valid = 1; cmd_write = w; cmd_reg_num = rn; cmd_wdata = wd;
        @(posedge clk);
        #1;
        cmd_valid = 0; cmd_write = 0; cmd_reg_num = '0; cmd_wdata = '0;
        cyc = 0; held = 0; got = 0; done = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            cache_inval = 0;
            st = int'(bus_reg_num_le) + int'(bus_wr_en) + int'(bus_rd_en);
            if (st > 1 || (st == 0 && bus_data_out !== 32'd0)) o.proto_err++;
            if (bus_reg_num_le) begin o.n_le++; o.le_cyc = cyc; o.le_dat = bus_data_out; end
            if (bus_wr_en)      begin o.n_wr++; o.wr_cyc = cyc; o.wr_dat = bus_data_out; end
            if (bus_rd_en)      begin o.n_rd++; o.rd_cyc = cyc; end
            if (cyc == inval_cyc) cache_inval = 1;
            if (rsp_valid) begin
                if (!got) begin
                    got = 1;
                    o.rsp_cyc = cyc; o.rsp_w = rsp_write; o.rsp_ill = rsp_illegal; o.rsp_rd = rsp_rdata;
                end else if ({rsp_write, rsp_illegal, rsp_rdata} !== {o.rsp_w, o.rsp_ill, o.rsp_rd}) begin
                    o.unstable++;
                end
                if (cmd_ready || st != 0) o.unstable++;
                if (held >= hold) begin
                    rsp_ready = 1;
                    @(posedge clk);
                    #1;
                    rsp_ready = 0;
                    cache_inval = 0;
                    done = 1;
                end
                held++;
            end else if (got) begin
                o.unstable++;
            end else if (cmd_ready) begin
                o.proto_err++;
            end
        end
        cache_inval = 0;
        if (!done) o.timeout = 1;
        @(negedge clk);
        o.rdy_after = cmd_ready;
        o.vld_after = rsp_valid;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(negedge clk);
        total++;
        if ({cmd_ready, rsp_valid, rsp_write, rsp_illegal, bus_reg_num_le, bus_wr_en, bus_rd_en} !== 7'b1000000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 1000000",
                     {cmd_ready, rsp_valid, rsp_write, rsp_illegal, bus_reg_num_le, bus_wr_en, bus_rd_en});
        end
        total++;
        if (rsp_rdata !== 32'd0 || bus_data_out !== 32'd0) begin
            bad++;
            $display("FAIL reset_data: got rdata=%h bus=%h want 0/0", rsp_rdata, bus_data_out);
        end
        reset = 0;
        m_cv = 0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got ready=%b valid=%b want 1/0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_write_miss();
        obs_t o; exp_t e;
        model_step(1, 32'd2, 32'd70000, 0, -1, e);
        run_cmd(1, 32'd2, 32'd70000, 0, -1, o);
        total++;
        if (o.le_cyc !== 1 || o.le_dat !== 32'h2 || o.n_le !== 1) begin
            bad++; $display("FAIL wr_miss_le: got c%0d %h n=%0d want c1 00000002 n=1", o.le_cyc, o.le_dat, o.n_le);
        end
        total++;
        if (o.wr_cyc !== 3 || o.wr_dat !== 32'h00011170 || o.n_rd !== 0) begin
            bad++; $display("FAIL wr_miss_wr: got c%0d %h rd=%0d want c3 00011170 rd=0", o.wr_cyc, o.wr_dat, o.n_rd);
        end
        total++;
        if (o.timeout || o.rsp_cyc !== 4 || {o.rsp_w, o.rsp_ill, o.rsp_rd} !== {1'b1, 1'b0, 32'd0}) begin
            bad++; $display("FAIL wr_miss_rsp: got c%0d w=%b ill=%b rd=%h want c4 1 0 0", o.rsp_cyc, o.rsp_w, o.rsp_ill, o.rsp_rd);
        end
        total++;
        if (o.proto_err !== 0 || o.rdy_after !== 1'b1 || o.vld_after !== 1'b0) begin
            bad++; $display("FAIL wr_miss_proto: got err=%0d rdy=%b vld=%b want 0 1 0", o.proto_err, o.rdy_after, o.vld_after);
        end
    endtask

    task automatic test_read_miss();
        obs_t o; exp_t e;
        model_step(0, 32'd8, 32'd0, 0, -1, e);
        run_cmd(0, 32'd8, 32'd0, 0, -1, o);
        total++;
        if (o.n_le !== 1 || o.le_dat !== 32'd8 || o.rd_cyc !== 3 || o.n_wr !== 0) begin
            bad++; $display("FAIL rd_miss_bus: got le=%0d %h rd@%0d wr=%0d want 1 8 rd@3 0", o.n_le, o.le_dat, o.rd_cyc, o.n_wr);
        end
        total++;
        if (o.timeout || o.rsp_cyc !== 5 || o.rsp_rd !== 32'h0000000E || o.rsp_w !== 1'b0) begin
            bad++; $display("FAIL rd_miss_rsp: got c%0d %h w=%b want c5 0000000e 0", o.rsp_cyc, o.rsp_rd, o.rsp_w);
        end
    endtask

    task automatic test_read_hit();
        obs_t o; exp_t e;
        model_step(0, 32'd8, 32'd0, 0, -1, e);
        run_cmd(0, 32'd8, 32'd0, 0, -1, o);
        total++;
        if (o.n_le !== 0 || o.rd_cyc !== 1) begin
            bad++; $display("FAIL rd_hit_bus: got le=%0d rd@%0d want 0 rd@1", o.n_le, o.rd_cyc);
        end
        total++;
        if (o.timeout || o.rsp_cyc !== 3 || o.rsp_rd !== 32'h0000000E) begin
            bad++; $display("FAIL rd_hit_rsp: got c%0d %h want c3 0000000e", o.rsp_cyc, o.rsp_rd);
        end
    endtask

    task automatic test_illegal();
        obs_t o; exp_t e;
        model_step(1, 32'h20, 32'hDEAD_BEEF, 0, -1, e);
        run_cmd(1, 32'h20, 32'hDEAD_BEEF, 0, -1, o);
        total++;
        if (o.n_le !== 1 || o.n_wr !== 0 || o.n_rd !== 0) begin
            bad++; $display("FAIL ill_bus: got le=%0d wr=%0d rd=%0d want 1 0 0", o.n_le, o.n_wr, o.n_rd);
        end
        total++;
        if (o.timeout || o.rsp_cyc !== 3 || o.rsp_ill !== 1'b1 || o.rsp_rd !== 32'd0) begin
            bad++; $display("FAIL ill_rsp: got c%0d ill=%b rd=%h want c3 1 0", o.rsp_cyc, o.rsp_ill, o.rsp_rd);
        end
        model_step(0, 32'd8, 32'd0, 0, -1, e);
        run_cmd(0, 32'd8, 32'd0, 0, -1, o);
        total++;
        if (o.n_le !== 1 || o.rsp_cyc !== 5 || o.rsp_rd !== 32'h0000000E || o.rsp_ill !== 1'b0) begin
            bad++; $display("FAIL ill_reload: got le=%0d c%0d %h ill=%b want 1 c5 0000000e 0", o.n_le, o.rsp_cyc, o.rsp_rd, o.rsp_ill);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o; exp_t e;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_ready: got %b want 1", cmd_ready);
        end
        cmd_valid = 1; cmd_write = 0; cmd_reg_num = 32'd2; cmd_wdata = '0;
        @(posedge clk);
        #1;
        cmd_valid = 0; cmd_reg_num = '0;
        repeat (3) @(negedge clk);
        total++;
        if (bus_rd_en !== 1'b1) begin
            bad++; $display("FAIL rstmid_rd: got %b want 1", bus_rd_en);
        end
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        total++;
        if ({bus_reg_num_le, bus_wr_en, bus_rd_en, rsp_valid, cmd_ready} !== 5'b00001 || bus_data_out !== 32'd0) begin
            bad++; $display("FAIL rstmid_state: got %b bus=%h want 00001 0",
                            {bus_reg_num_le, bus_wr_en, bus_rd_en, rsp_valid, cmd_ready}, bus_data_out);
        end
        reset = 0;
        m_cv = 0;
        model_step(0, 32'd2, 32'd0, 0, -1, e);
        run_cmd(0, 32'd2, 32'd0, 0, -1, o);
        total++;
        if (o.n_le !== 1 || o.rsp_cyc !== 5 || o.rsp_rd !== 32'd70000) begin
            bad++; $display("FAIL rstmid_reload: got le=%0d c%0d %h want 1 c5 %h", o.n_le, o.rsp_cyc, o.rsp_rd, 32'd70000);
        end
    endtask

    task automatic test_backpressure();
        obs_t o; exp_t e;
        model_step(0, 32'd8, 32'd0, 10, 9, e);
        run_cmd(0, 32'd8, 32'd0, 10, 9, o);
        total++;
        if (o.timeout || o.unstable !== 0 || o.proto_err !== 0) begin
            bad++; $display("FAIL bp_hold: got unstable=%0d err=%0d to=%b want 0 0 0", o.unstable, o.proto_err, o.timeout);
        end
        total++;
        if (o.rsp_cyc !== 5 || o.rsp_rd !== 32'h0000000E || o.rdy_after !== 1'b1) begin
            bad++; $display("FAIL bp_rsp: got c%0d %h rdy=%b want c5 0000000e 1", o.rsp_cyc, o.rsp_rd, o.rdy_after);
        end
        model_step(0, 32'd8, 32'd0, 0, -1, e);
        run_cmd(0, 32'd8, 32'd0, 0, -1, o);
        total++;
        if (o.n_le !== 1 || o.rsp_cyc !== 5) begin
            bad++; $display("FAIL bp_inval: got le=%0d c%0d want 1 c5", o.n_le, o.rsp_cyc);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o; exp_t e;
        model_step(1, 32'd8, 32'h1234, 0, -1, e);
        run_cmd(1, 32'd8, 32'h1234, 0, -1, o);
        total++;
        if (o.n_le !== 0 || o.wr_cyc !== 1 || o.wr_dat !== 32'h1234 || o.rsp_cyc !== 2) begin
            bad++; $display("FAIL b2b_wr_hit: got le=%0d wr@%0d %h c%0d want 0 wr@1 1234 c2", o.n_le, o.wr_cyc, o.wr_dat, o.rsp_cyc);
        end
        model_step(0, 32'd8, 32'd0, 0, -1, e);
        run_cmd(0, 32'd8, 32'd0, 0, -1, o);
        total++;
        if (o.n_le !== 0 || o.rsp_cyc !== 3 || o.rsp_rd !== 32'h1234) begin
            bad++; $display("FAIL b2b_rd_hit: got le=%0d c%0d %h want 0 c3 1234", o.n_le, o.rsp_cyc, o.rsp_rd);
        end
    endtask

    task automatic test_inval_check();
        obs_t o; exp_t e;
        model_step(1, 32'd31, 32'hA5A5, 0, 2, e);
        run_cmd(1, 32'd31, 32'hA5A5, 0, 2, o);
        model_step(0, 32'd31, 32'd0, 0, -1, e);
        run_cmd(0, 32'd31, 32'd0, 0, -1, o);
        total++;
        if (o.n_le !== 1 || o.rsp_cyc !== 5 || o.rsp_rd !== 32'hA5A5) begin
            bad++; $display("FAIL inval_check: got le=%0d c%0d %h want 1 c5 0000a5a5", o.n_le, o.rsp_cyc, o.rsp_rd);
        end
    endtask

    task automatic test_random();
        obs_t o; exp_t e;
        logic w;
        logic [31:0] rn, wd, prev;
        int hold, inv, x_le, x_wr, x_rd;
        logic [31:0] x_led, x_wrd;
        prev = 32'd8;
        for (int i = 0; i < 40; i++) begin
            w  = 1'($urandom_range(0, 1));
            wd = $urandom;
            case ($urandom_range(0, 7))
                0, 1:    rn = 32'd8;
                2:       rn = 32'd2;
                3:       rn = 32'd31;
                4:       rn = 32'd0;
                5:       rn = 32'd32;
                6:       rn = 32'hFFFF_FFFF;
                default: rn = prev;
            endcase
            hold = $urandom_range(0, 3);
            inv  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1;
            model_step(w, rn, wd, hold, inv, e);
            run_cmd(w, rn, wd, hold, inv, o);
            prev = rn;
            x_le  = e.n_le ? 1 : -1;
            x_led = e.n_le ? rn : 32'd0;
            x_wr  = e.n_wr ? e.acc : -1;
            x_wrd = e.n_wr ? wd : 32'd0;
            x_rd  = e.n_rd ? e.acc : -1;
            total++;
            if (o.timeout || {o.n_le, o.n_wr, o.n_rd, o.rsp_cyc} !== {e.n_le, e.n_wr, e.n_rd, e.rsp}) begin
                bad++; $display("FAIL rnd%0d_seq: got le=%0d wr=%0d rd=%0d rsp@%0d want le=%0d wr=%0d rd=%0d rsp@%0d",
                                i, o.n_le, o.n_wr, o.n_rd, o.rsp_cyc, e.n_le, e.n_wr, e.n_rd, e.rsp);
            end
            total++;
            if ({o.le_cyc, o.le_dat, o.wr_cyc, o.wr_dat, o.rd_cyc} !== {x_le, x_led, x_wr, x_wrd, x_rd}) begin
                bad++; $display("FAIL rnd%0d_bus: got le@%0d %h wr@%0d %h rd@%0d want le@%0d %h wr@%0d %h rd@%0d",
                                i, o.le_cyc, o.le_dat, o.wr_cyc, o.wr_dat, o.rd_cyc, x_le, x_led, x_wr, x_wrd, x_rd);
            end
            total++;
            if ({o.rsp_w, o.rsp_ill, o.rsp_rd} !== {w, e.ill, e.rdata}) begin
                bad++; $display("FAIL rnd%0d_rsp: got w=%b ill=%b rd=%h want w=%b ill=%b rd=%h",
                                i, o.rsp_w, o.rsp_ill, o.rsp_rd, w, e.ill, e.rdata);
            end
            total++;
            if (o.proto_err !== 0 || o.unstable !== 0 || o.rdy_after !== 1'b1 || o.vld_after !== 1'b0) begin
                bad++; $display("FAIL rnd%0d_proto: got err=%0d unstable=%0d rdy=%b vld=%b want 0 0 1 0",
                                i, o.proto_err, o.unstable, o.rdy_after, o.vld_after);
            end
        end
    endtask

    initial begin
        reset = 1; cmd_valid = 0; cmd_write = 0; cmd_reg_num = '0; cmd_wdata = '0;
        rsp_ready = 0; cache_inval = 0;
        for (int i = 0; i < 32; i++) begin
            rx_mem[i] = 32'h100 + i;
            m_mem[i]  = 32'h100 + i;
        end
        rx_mem[8] = 32'd14;
        m_mem[8]  = 32'd14;
        m_cv = 0;
        m_cn = '0;
        test_reset();
        test_write_miss();
        test_read_miss();
        test_read_hit();
        test_illegal();
        test_reset_mid();
        test_backpressure();
        test_back_to_back();
        test_inval_check();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
